// File: rtl/mac3_pkg.sv
// Shared types and constants for the 3-term MAC reduction path.
package mac3_pkg;

    localparam int          FP_W    = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Leading-zero count of a 27-bit significand; returns 27 for all-zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/float_add_sub.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// subnormals supported, NaN/Inf propagated.
module float_add_sub
    import mac3_pkg::*;
(
    input  logic            s_axis_a_tvalid,
    input  logic [FP_W-1:0] s_axis_a_tdata,
    input  logic            s_axis_b_tvalid,
    input  logic [FP_W-1:0] s_axis_b_tdata,
    output logic            m_axis_result_tvalid,
    output logic [FP_W-1:0] m_axis_result_tdata
);

    logic [31:0] x, y;
    logic        sx, sy, eff_sub, x_nan, y_nan, x_inf, y_inf, sticky, up;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, ys, n;
    logic [27:0] sum;
    logic [9:0]  e, sh;
    logic [4:0]  lz;
    logic [24:0] m25;
    logic [23:0] m24;

    assign m_axis_result_tvalid = s_axis_a_tvalid & s_axis_b_tvalid;

    // Align, add/subtract magnitudes, normalise, round, then patch specials.
    always_comb begin
        // order operands so x has the larger magnitude
        if (s_axis_b_tdata[30:0] > s_axis_a_tdata[30:0]) begin
            x = s_axis_b_tdata;
            y = s_axis_a_tdata;
        end else begin
            x = s_axis_a_tdata;
            y = s_axis_b_tdata;
        end
        sx      = x[31];
        sy      = y[31];
        eff_sub = sx ^ sy;
        x_nan   = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan   = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        x_inf   = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf   = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);

        // subnormals use exponent 1 with no hidden bit; 3 guard/round/sticky bits
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
        my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
        d  = ex - ey;

        if (d >= 8'd27) begin
            ys     = '0;
            sticky = |my;
        end else begin
            ys     = my >> d[4:0];
            sticky = |(my << (5'd27 - d[4:0]));
        end
        ys[0] = ys[0] | sticky;

        sum = eff_sub ? ({1'b0, mx} - {1'b0, ys}) : ({1'b0, mx} + {1'b0, ys});

        e  = {2'b00, ex};
        lz = lzc27(sum[26:0]);
        sh = '0;
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'd1;
        end else begin
            // stop shifting at the subnormal boundary
            sh = ({5'd0, lz} > (e - 10'd1)) ? (e - 10'd1) : {5'd0, lz};
            n  = sum[26:0] << sh;
            e  = e - sh;
        end

        up  = n[2] & (n[1] | n[0] | n[3]);
        m25 = {1'b0, n[26:3]} + {24'd0, up};
        if (m25[24]) begin
            m24 = m25[24:1];
            e   = e + 10'd1;
        end else begin
            m24 = m25[23:0];
        end

        if (e >= 10'd255)
            m_axis_result_tdata = {sx, 8'hFF, 23'd0};
        else
            m_axis_result_tdata = {sx, (m24[23] ? e[7:0] : 8'd0), m24[22:0]};

        if (sum == 28'd0)
            m_axis_result_tdata = {(eff_sub ? 1'b0 : sx), 31'd0};
        if (x_inf)
            m_axis_result_tdata = (y_inf && eff_sub) ? 32'h7FC0_0000 : {sx, 8'hFF, 23'd0};
        if (x_nan || y_nan)
            m_axis_result_tdata = 32'h7FC0_0000;
    end

endmodule

// File: rtl/mac3_accum.sv
// Frame accumulator: sums N consecutive float beats left-to-right and
// presents one result per frame on a valid/ready port.
module mac3_accum
    import mac3_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_data,
    output logic [LEN_W-1:0] out_beats
);

    state_t            state_q, state_d;
    logic [FP_W-1:0]   acc_q, acc_d, sum;
    logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d, eff_len, cnt_inc;
    logic              accept;

    float_add_sub u_add (
        .s_axis_a_tvalid      (1'b1),
        .s_axis_a_tdata       (acc_q),
        .s_axis_b_tvalid      (1'b1),
        .s_axis_b_tdata       (in_data),
        .m_axis_result_tvalid (),
        .m_axis_result_tdata  (sum)
    );

    // Ready depends only on state; held low while reset is applied.
    assign in_ready  = (state_q != OUT) && !rst;
    assign accept    = in_valid && in_ready;
    assign eff_len   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign cnt_inc   = cnt_q + 1'b1;
    assign out_valid = (state_q == OUT);
    assign out_data  = acc_q;
    assign out_beats = cnt_q;

    // Next-state: first beat loads, later beats add, OUT holds until taken.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: if (accept) begin
                acc_d   = in_data;
                cnt_d   = LEN_W'(1);
                len_d   = eff_len;
                state_d = (in_last || eff_len == LEN_W'(1)) ? OUT : ACC;
            end
            ACC: if (accept) begin
                acc_d   = sum;
                cnt_d   = cnt_inc;
                state_d = (in_last || cnt_inc == len_q) ? OUT : ACC;
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator and counters; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= FP_ZERO;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule
